// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the virtual-disk sector request arbiter.
// Device indices match the requester slot wiring used by the buffer steering.
package sd_arb_pkg;

  localparam int LBA_W = 32;
  localparam int DEV_W = 2;

  localparam logic [DEV_W-1:0] FDD0 = 2'd0;
  localparam logic [DEV_W-1:0] FDD1 = 2'd1;
  localparam logic [DEV_W-1:0] HDD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Round-robin selector: first pending requester at or after rr_ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] pending,
  input  logic [1:0]      rr_ptr,
  output logic            valid,
  output logic [1:0]      idx
);

  // Scan from the farthest slot back to rr_ptr so the nearest hit is written last.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (pending[j[1:0]]) begin
        valid = 1'b1;
        idx   = j[1:0];
      end
    end
  end

endmodule

// File: rtl/sd_req_arbiter.sv
// Arbitrates virtual-disk sector read/write requests onto the single host
// request channel, with round-robin fairness, cancel and issue timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant; pick next pending requester from rr_ptr
// ST_ISSUE | sd_rd/sd_wr asserted, waiting for sd_ack; cancel/timeout
// ST_XFER  | host transferring; sd_ack routed to the granted req_ack
// ST_DONE  | one-cycle wrap-up; rr_ptr moves past the granted requester
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int TMO_W = 24
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_rd,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ*LBA_W-1:0] req_lba,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       req_busy,
  output logic                  sd_rd,
  output logic                  sd_wr,
  output logic [LBA_W-1:0]      sd_lba,
  output logic [DEV_W-1:0]      sd_dev,
  input  logic                  sd_ack,
  output logic                  tmo_err
);

  arb_state_t       state;
  arb_state_t       state_nx;
  logic [1:0]       grant;
  logic [1:0]       rr_ptr;
  logic [TMO_W-1:0] tmo_cnt;

  logic [NREQ-1:0]  pending;
  logic [NREQ-1:0]  grant_oh;
  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic             grant_live;
  logic             tmo_hit;
  logic [1:0]       ptr_after_grant;

  assign pending         = req_rd | req_wr;
  assign grant_oh        = NREQ'(1) << grant;
  assign grant_live      = |(pending & grant_oh);
  assign tmo_hit         = (state == ST_ISSUE) && !sd_ack && grant_live && (&tmo_cnt);
  assign ptr_after_grant = (grant == 2'(NREQ - 1)) ? 2'd0 : grant + 2'd1;
  assign sd_dev          = grant;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // sd_ack wins over a same-cycle request drop or timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (pick_valid) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (sd_ack)             state_nx = ST_XFER;
        else if (!grant_live)   state_nx = ST_IDLE;
        else if (&tmo_cnt)      state_nx = ST_IDLE;
      end
      ST_XFER: begin
        if (!sd_ack) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_busy = '0;
    req_ack  = '0;
    tmo_err  = tmo_hit;
    if (state != ST_IDLE) req_busy = grant_oh;
    if ((state == ST_ISSUE || state == ST_XFER) && sd_ack) req_ack = grant_oh;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      grant   <= 2'd0;
      rr_ptr  <= 2'd0;
      tmo_cnt <= '0;
      sd_lba  <= '0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
    end else begin
      if (state == ST_IDLE && pick_valid) begin
        grant   <= pick_idx;
        sd_lba  <= req_lba[int'(pick_idx)*LBA_W +: LBA_W];
        tmo_cnt <= '0;
        // A requester raising both lines is served as a read.
        sd_rd   <= req_rd[pick_idx];
        sd_wr   <= ~req_rd[pick_idx];
      end else if (state == ST_ISSUE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (state_nx != ST_ISSUE) begin
          sd_rd <= 1'b0;
          sd_wr <= 1'b0;
        end
        if (tmo_hit) rr_ptr <= ptr_after_grant;
      end else if (state == ST_DONE) begin
        rr_ptr <= ptr_after_grant;
      end
    end
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sd_req_arbiter;
  import sd_arb_pkg::*;

  localparam int N    = 4;
  localparam int TW   = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_rd  = '0;
  logic [N-1:0]    req_wr  = '0;
  logic [N*32-1:0] req_lba = '0;
  logic            sd_ack  = 1'b0;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    req_busy;
  logic            sd_rd;
  logic            sd_wr;
  logic [31:0]     sd_lba;
  logic [1:0]      sd_dev;
  logic            tmo_err;

  sd_req_arbiter #(.NREQ(N), .TMO_W(TW)) dut (
    .clk_sys (clk_sys), .reset_n (reset_n),
    .req_rd  (req_rd),  .req_wr  (req_wr),  .req_lba (req_lba),
    .req_ack (req_ack), .req_busy(req_busy),
    .sd_rd   (sd_rd),   .sd_wr   (sd_wr),   .sd_lba  (sd_lba),
    .sd_dev  (sd_dev),  .sd_ack  (sd_ack),  .tmo_err (tmo_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_own;     // granted requester, -1 when none
  bit          m_wait;    // waiting for host ack
  bit          m_xfer;    // host transfer running
  bit          m_done;    // wrap-up cycle
  int          m_age;     // cycles spent waiting for ack
  int          m_rr;
  bit          m_isrd;
  logic [31:0] m_lba;
  int          m_dev;

  function automatic bit pend(input int i);
    return req_rd[i] | req_wr[i];
  endfunction

  task automatic model_reset();
    m_own = -1; m_wait = 0; m_xfer = 0; m_done = 0;
    m_age = 0;  m_rr = 0;   m_isrd = 0; m_lba = '0; m_dev = 0;
  endtask

  task automatic model_step();
    if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (pend(j)) begin
          m_own = j; m_wait = 1; m_age = 0; m_dev = j;
          m_lba = req_lba[j*32 +: 32];
          m_isrd = req_rd[j];
          break;
        end
      end
    end else if (m_wait) begin
      if (sd_ack) begin
        m_wait = 0; m_xfer = 1;
      end else if (!pend(m_own)) begin
        m_wait = 0; m_own = -1;
      end else if (m_age == TMAX) begin
        m_wait = 0; m_rr = (m_own + 1) % N; m_own = -1;
      end else begin
        m_age++;
      end
    end else if (m_xfer) begin
      if (!sd_ack) begin
        m_xfer = 0; m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0; m_rr = (m_own + 1) % N; m_own = -1;
    end
  endtask

  task automatic compare();
    logic [N-1:0] e_busy, e_ack;
    bit e_rd, e_wr, e_tmo;
    if (!reset_n) model_reset();
    e_busy = (m_own >= 0) ? (N'(1) << m_own) : '0;
    e_ack  = ((m_own >= 0) && (m_wait || m_xfer) && sd_ack) ? e_busy : '0;
    e_rd   = m_wait && m_isrd;
    e_wr   = m_wait && !m_isrd;
    e_tmo  = m_wait && (m_age == TMAX) && !sd_ack && pend(m_own);
    chk("busy",    64'(req_busy), 64'(e_busy));
    chk("req_ack", 64'(req_ack),  64'(e_ack));
    chk("sd_rd",   64'(sd_rd),    64'(e_rd));
    chk("sd_wr",   64'(sd_wr),    64'(e_wr));
    chk("tmo_err", 64'(tmo_err),  64'(e_tmo));
    chk("sd_lba",  64'(sd_lba),   64'(m_lba));
    chk("sd_dev",  64'(sd_dev),   64'(m_dev));
  endtask

  // ---------------- stimulus agents ----------------
  bit          rq_on[N];
  bit          want_rd[N];
  bit          want_wr[N];
  logic [31:0] want_lba[N];
  bit          drop_req[N];
  bit          hold_req[N];
  bit          rand_en    = 0;
  bit          host_en    = 1;
  int          host_delay = 5;
  int          host_hold  = 8;
  int          h_wait = 0, h_len = 0;
  bit          h_on = 0, stray = 0, host_kill = 0;
  logic [N-1:0] s_ack = '0, s_busy = '0;
  bit          s_sdreq = 0;
  bit          rst_val = 0;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq_on[i] && ((s_ack[i] && !hold_req[i]) || drop_req[i] ||
          (rand_en && s_busy[i] && !s_ack[i] && ($urandom % 40) == 0))) begin
        req_rd[i] = 1'b0; req_wr[i] = 1'b0; rq_on[i] = 0;
      end else if (!rq_on[i] && (want_rd[i] || want_wr[i])) begin
        req_rd[i] = want_rd[i]; req_wr[i] = want_wr[i];
        req_lba[i*32 +: 32] = want_lba[i];
        rq_on[i] = 1; want_rd[i] = 0; want_wr[i] = 0;
      end else if (!rq_on[i] && rand_en && ($urandom % 6) == 0) begin
        int r;
        r = $urandom_range(0, 3);
        req_rd[i] = (r != 2); req_wr[i] = (r >= 2);
        req_lba[i*32 +: 32] = $urandom;
        rq_on[i] = 1;
      end
      drop_req[i] = 0;
    end
    if (stray) begin
      sd_ack = 1'b0; stray = 0;
    end
    if (host_kill) begin
      sd_ack = 1'b0; h_on = 0; h_wait = 0; host_kill = 0;
    end else if (h_on) begin
      h_len++;
      if (h_len >= host_hold) begin
        sd_ack = 1'b0; h_on = 0; h_wait = 0;
      end
    end else if (s_sdreq) begin
      if (h_wait == 0 && rand_en) begin
        host_delay = $urandom_range(1, 20);
        host_hold  = $urandom_range(1, 8);
      end
      h_wait++;
      if (host_en && h_wait >= host_delay) begin
        sd_ack = 1'b1; h_on = 1; h_len = 0;
      end
    end else begin
      h_wait = 0;
      if (rand_en && ($urandom % 25) == 0) begin
        sd_ack = 1'b1; stray = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (!reset_n) model_reset();
    else          model_step();
    #1;
    drive();
    reset_n = rst_val;
    @(negedge clk_sys);
    compare();
    s_ack   = req_ack;
    s_busy  = req_busy;
    s_sdreq = sd_rd | sd_wr;
  endtask

  task automatic wait_grant(output int dev, output int t);
    t = 0;
    do begin
      tick(); t++;
    end while (req_busy == '0 && t < 60);
    if (req_busy == '0) chk("grant_timeout", 64'(t), 64'(0));
    dev = int'(sd_dev);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (req_busy != '0 && t < 80) begin
      tick(); t++;
    end
    if (req_busy != '0) chk("idle_timeout", 64'(t), 64'(0));
  endtask

  initial begin
    int n, acks, dev, t, tmo_seen;
    model_reset();
    for (int i = 0; i < N; i++) begin
      rq_on[i] = 0; want_rd[i] = 0; want_wr[i] = 0; want_lba[i] = '0;
      drop_req[i] = 0; hold_req[i] = 0;
    end

    // reset state
    repeat (3) tick();
    chk("rst_busy", 64'(req_busy), 64'(0));
    chk("rst_sd_rd", 64'(sd_rd), 64'(0));
    rst_val = 1;
    repeat (2) tick();

    // single read from requester 1
    host_delay = 5; host_hold = 8;
    want_rd[1] = 1; want_lba[1] = 32'h0000_0010;
    n = 0;
    do begin tick(); n++; end while (!sd_rd && n < 10);
    chk("rd_latency", 64'(n), 64'(2));
    chk("rd_dev", 64'(sd_dev), 64'(FDD1));
    chk("rd_lba", 64'(sd_lba), 64'h10);
    chk("rd_not_wr", 64'(sd_wr), 64'(0));
    acks = 0; n = 0;
    while (req_busy != '0 && n < 40) begin
      tick(); n++;
      if (req_ack[1]) acks++;
    end
    chk("ack_len", 64'(acks), 64'(8));
    // pointer now at 2: of {0,2}, 2 goes first
    want_rd[0] = 1; want_lba[0] = 32'hA0;
    want_rd[2] = 1; want_lba[2] = 32'hA2;
    wait_grant(dev, t);
    chk("rr_after_read", 64'(dev), 64'(HDD));
    wait_idle();
    wait_grant(dev, t);
    chk("rr_wrap", 64'(dev), 64'(FDD0));
    wait_idle();

    // round robin from reset: 0,1,3 with one idle cycle between grants
    rst_val = 0; tick(); rst_val = 1; tick();
    want_rd[0] = 1; want_rd[1] = 1; want_rd[3] = 1;
    want_lba[0] = 32'h100; want_lba[1] = 32'h101; want_lba[3] = 32'h103;
    wait_grant(dev, t);
    chk("rr_order0", 64'(dev), 64'(0));
    wait_idle();
    wait_grant(dev, t);
    chk("rr_order1", 64'(dev), 64'(1));
    chk("rr_gap1", 64'(t), 64'(1));
    wait_idle();
    wait_grant(dev, t);
    chk("rr_order2", 64'(dev), 64'(3));
    chk("rr_gap2", 64'(t), 64'(1));
    wait_idle();

    // cancel: write on 2 dropped 3 cycles into ISSUE
    host_en = 0;
    want_wr[2] = 1; want_lba[2] = 32'h2222;
    wait_grant(dev, t);
    chk("cancel_sd_wr", 64'(sd_wr), 64'(1));
    acks = 0; tmo_seen = 0;
    repeat (3) begin
      tick();
      if (req_ack != '0) acks++;
      if (tmo_err) tmo_seen++;
    end
    drop_req[2] = 1;
    repeat (2) begin
      tick();
      if (req_ack != '0) acks++;
      if (tmo_err) tmo_seen++;
    end
    chk("cancel_wr_low", 64'(sd_wr), 64'(0));
    chk("cancel_no_ack", 64'(acks), 64'(0));
    chk("cancel_no_tmo", 64'(tmo_seen), 64'(0));
    host_en = 1;
    want_rd[1] = 1; want_rd[3] = 1;
    wait_grant(dev, t);
    chk("cancel_rr_kept", 64'(dev), 64'(FDD1));
    wait_idle();
    wait_grant(dev, t);
    wait_idle();

    // timeout on requester 0, requester 1 waiting
    host_en = 0; host_delay = 5; host_hold = 8;
    want_rd[0] = 1; want_lba[0] = 32'h300;
    wait_grant(dev, t);
    want_rd[1] = 1; want_lba[1] = 32'h301;
    n = 0;
    do begin tick(); n++; end while (!tmo_err && n < 40);
    chk("tmo_cycles", 64'(n), 64'(TMAX));
    tick();
    chk("tmo_single", 64'(tmo_err), 64'(0));
    host_en = 1;
    wait_grant(dev, t);
    chk("tmo_next_grant", 64'(dev), 64'(FDD1));
    wait_idle();
    wait_grant(dev, t);
    wait_idle();

    // read wins when both lines are high
    want_rd[3] = 1; want_wr[3] = 1; want_lba[3] = 32'h333;
    wait_grant(dev, t);
    chk("both_rd", 64'(sd_rd), 64'(1));
    chk("both_wr", 64'(sd_wr), 64'(0));
    wait_idle();

    // reset in the middle of a transfer
    host_delay = 1; host_hold = 30;
    hold_req[2] = 1;
    want_rd[2] = 1; want_lba[2] = 32'h444;
    wait_grant(dev, t);
    n = 0;
    while (!req_ack[2] && n < 10) begin tick(); n++; end
    tick();
    rst_val = 0;
    tick();
    chk("mrst_busy", 64'(req_busy), 64'(0));
    chk("mrst_ack", 64'(req_ack), 64'(0));
    chk("mrst_lba", 64'(sd_lba), 64'(0));
    tick();
    rst_val = 1;
    tick();
    chk("mrst_stray_ack", 64'(req_ack), 64'(0));
    host_kill = 1; hold_req[2] = 0; host_hold = 4;
    tick();
    chk("mrst_regrant", 64'(sd_dev), 64'(HDD));
    chk("mrst_regrant_ack", 64'(req_ack), 64'(0));
    wait_idle();

    // randomized traffic
    rand_en = 1;
    repeat (4000) tick();
    rand_en = 0; host_en = 1; host_delay = 3; host_hold = 2;
    repeat (300) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
